// File: rtl/ram_sdp_clr_if.sv
// ---------------------------------------------------------------------------
// ram_sdp_clr_if
// Bus bundle for the ram_sdp_clr simple-dual-port RAM.
//   master : drives clear request, write port and read port strobes/addresses
//   slave  : returns busy, read data/qualifier and the error pulse
// Signals:
//   clr_req  - single-cycle request to zero the whole memory
//   busy     - clear sweep in progress, ops are dropped
//   wr_en/wr_addr/wr_be/wr_data - write port with byte-lane enables
//   rd_en/rd_addr               - read port request
//   rd_data/rd_valid            - read result and its one-cycle qualifier
//   err      - one-cycle pulse for a dropped or out-of-range op
// ---------------------------------------------------------------------------
interface ram_sdp_clr_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic                   clr_req;
    logic                   busy;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W/8-1:0]    wr_be;
    logic [DATA_W-1:0]      wr_data;
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic                   rd_valid;
    logic                   err;

    modport master (
        output clr_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        input  busy, rd_data, rd_valid, err
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
        output busy, rd_data, rd_valid, err
    );
endinterface

// File: rtl/ram_sdp_clr.sv
// ---------------------------------------------------------------------------
// ram_sdp_clr
// Parametrised simple-dual-port synchronous RAM with byte-lane writes,
// 1- or 2-cycle read latency, optional read-during-write forwarding and a
// hardware clear sequencer that zeroes the array after reset or on request.
// Ports:
//   clk    - single rising-edge clock
//   rst_n  - asynchronous active-low reset (restarts the clear sweep)
//   bus    - ram_sdp_clr_if slave modport (clear, write, read, busy, err)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | sweeping mem[clr_ptr] <= 0, one word per cycle; ops dropped
// ST_IDLE  | normal operation; clr_req starts a new sweep
// ---------------------------------------------------------------------------
module ram_sdp_clr #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int RD_LAT = 1,
    parameter int WR_FWD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    ram_sdp_clr_if.slave    bus
);

    localparam int                NB      = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic                r_busy;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd_d1;
    logic                r_rd_v1;

    logic                w_clr_go;
    logic                w_block;
    logic                w_wr_oor;
    logic                w_rd_oor;
    logic                w_wr_ok;
    logic                w_rd_acc;
    logic                w_err_nxt;
    logic [DATA_W-1:0]   w_wr_merge;
    logic [DATA_W-1:0]   w_rd_word;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_rd_valid;

    // A clear accepted this cycle already blocks ops in the same cycle.
    assign w_clr_go  = (r_state == ST_IDLE) && bus.clr_req;
    assign w_block   = (r_state == ST_CLEAR) || w_clr_go;
    assign w_wr_oor  = (int'(bus.wr_addr) >= DEPTH);
    assign w_rd_oor  = (int'(bus.rd_addr) >= DEPTH);
    assign w_wr_ok   = !w_block && bus.wr_en && !w_wr_oor;
    assign w_rd_acc  = !w_block && bus.rd_en;
    assign w_err_nxt = w_block ? (bus.wr_en || bus.rd_en)
                               : ((bus.wr_en && w_wr_oor) || (bus.rd_en && w_rd_oor));

    // Old word with the enabled lanes replaced; used for both the write and
    // the forwarded read.
    always_comb begin
        w_wr_merge = r_mem[bus.wr_addr];
        for (int i = 0; i < NB; i++) begin
            if (bus.wr_be[i]) begin
                w_wr_merge[8*i +: 8] = bus.wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_rd_word = r_mem[bus.rd_addr];
        if (w_rd_oor) begin
            w_rd_word = '0;
        end else if ((WR_FWD != 0) && w_wr_ok && (bus.wr_addr == bus.rd_addr)) begin
            w_rd_word = w_wr_merge;
        end
    end

    // Array has no reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[bus.wr_addr] <= w_wr_merge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_ptr == LP_LAST) begin
                        r_state   <= ST_IDLE;
                        r_clr_ptr <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_ptr <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_d1 <= '0;
            r_rd_v1 <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err   <= w_err_nxt;
            r_rd_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_d1 <= w_rd_word;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] r_rd_d2;
            logic              r_rd_v2;

            // Second stage is independent of the FSM so in-flight reads
            // still complete when a sweep starts.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_d2 <= '0;
                    r_rd_v2 <= 1'b0;
                end else begin
                    r_rd_v2 <= r_rd_v1;
                    if (r_rd_v1) begin
                        r_rd_d2 <= r_rd_d1;
                    end
                end
            end

            assign w_rd_data  = r_rd_d2;
            assign w_rd_valid = r_rd_v2;
        end else begin : g_lat1
            assign w_rd_data  = r_rd_d1;
            assign w_rd_valid = r_rd_v1;
        end
    endgenerate

    assign bus.busy     = r_busy;
    assign bus.err      = r_err;
    assign bus.rd_data  = w_rd_data;
    assign bus.rd_valid = w_rd_valid;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// ---------------------------------------------------------------------------
// tb_ram_sdp_clr
// Two instances driven with identical stimulus:
//   A: DATA_W=32 DEPTH=8 RD_LAT=2 WR_FWD=1
//   B: DATA_W=32 DEPTH=6 RD_LAT=1 WR_FWD=0
// A behavioural model per instance pushes expected reads into a queue with
// their due cycle; outputs are compared 1ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_ram_sdp_clr;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        t_clr_req, t_wr_en, t_rd_en;
    logic [2:0]  t_wr_addr, t_rd_addr;
    logic [3:0]  t_wr_be;
    logic [31:0] t_wr_data;

    ram_sdp_clr_if #(.DATA_W(32), .ADDR_W(3)) if_a ();
    ram_sdp_clr_if #(.DATA_W(32), .ADDR_W(3)) if_b ();

    assign if_a.clr_req = t_clr_req;
    assign if_a.wr_en   = t_wr_en;
    assign if_a.wr_addr = t_wr_addr;
    assign if_a.wr_be   = t_wr_be;
    assign if_a.wr_data = t_wr_data;
    assign if_a.rd_en   = t_rd_en;
    assign if_a.rd_addr = t_rd_addr;
    assign if_b.clr_req = t_clr_req;
    assign if_b.wr_en   = t_wr_en;
    assign if_b.wr_addr = t_wr_addr;
    assign if_b.wr_be   = t_wr_be;
    assign if_b.wr_data = t_wr_data;
    assign if_b.rd_en   = t_rd_en;
    assign if_b.rd_addr = t_rd_addr;

    ram_sdp_clr #(.DATA_W(32), .DEPTH(8), .ADDR_W(3), .RD_LAT(2), .WR_FWD(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    ram_sdp_clr #(.DATA_W(32), .DEPTH(6), .ADDR_W(3), .RD_LAT(1), .WR_FWD(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q_a[$];
    exp_t        q_b[$];
    logic [31:0] m_mem [2][8];
    bit          m_busy [2];
    int          m_ptr [2];
    bit          e_err [2];
    logic [31:0] m_last [2];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;

    function automatic int dep(int n);
        return (n == 0) ? 8 : 6;
    endfunction

    function automatic int lat(int n);
        return (n == 0) ? 2 : 1;
    endfunction

    function automatic bit fwd(int n);
        return (n == 0);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Expected effect of the coming edge on instance n, from the driven inputs.
    task automatic model_edge(int n);
        bit          blk, wr_oor, rd_oor, wr_ok;
        logic [31:0] merged, val;
        exp_t        e;
        blk    = m_busy[n] || t_clr_req;
        wr_oor = int'(t_wr_addr) >= dep(n);
        rd_oor = int'(t_rd_addr) >= dep(n);
        e_err[n] = blk ? (t_wr_en || t_rd_en)
                       : ((t_wr_en && wr_oor) || (t_rd_en && rd_oor));
        wr_ok  = !blk && t_wr_en && !wr_oor;
        merged = m_mem[n][t_wr_addr];
        for (int i = 0; i < 4; i++)
            if (t_wr_be[i]) merged[8*i +: 8] = t_wr_data[8*i +: 8];
        if (!blk && t_rd_en) begin
            if (rd_oor)                                           val = '0;
            else if (fwd(n) && wr_ok && t_wr_addr == t_rd_addr)  val = merged;
            else                                                  val = m_mem[n][t_rd_addr];
            e.data = val;
            e.due  = cyc + lat(n);
            if (n == 0) q_a.push_back(e);
            else        q_b.push_back(e);
        end
        if (wr_ok) m_mem[n][t_wr_addr] = merged;
        if (m_busy[n]) begin
            m_mem[n][m_ptr[n]] = '0;
            if (m_ptr[n] == dep(n) - 1) m_busy[n] = 1'b0;
            else                        m_ptr[n]++;
        end else if (t_clr_req) begin
            m_busy[n] = 1'b1;
            m_ptr[n]  = 0;
        end
    endtask

    task automatic check_out(int n);
        logic        busy_o, err_o, v_o;
        logic [31:0] d_o;
        bit          have;
        exp_t        h;
        string       pfx;
        pfx    = (n == 0) ? "A" : "B";
        busy_o = (n == 0) ? if_a.busy     : if_b.busy;
        err_o  = (n == 0) ? if_a.err      : if_b.err;
        v_o    = (n == 0) ? if_a.rd_valid : if_b.rd_valid;
        d_o    = (n == 0) ? if_a.rd_data  : if_b.rd_data;
        chk({pfx, ".busy"}, {31'd0, busy_o}, {31'd0, m_busy[n]});
        chk({pfx, ".err"},  {31'd0, err_o},  {31'd0, e_err[n]});
        if (n == 0) have = (q_a.size() > 0) && (q_a[0].due == cyc);
        else        have = (q_b.size() > 0) && (q_b[0].due == cyc);
        if (have) begin
            if (n == 0) h = q_a.pop_front();
            else        h = q_b.pop_front();
            chk({pfx, ".rd_valid"}, {31'd0, v_o}, 32'd1);
            chk({pfx, ".rd_data"}, d_o, h.data);
            m_last[n] = h.data;
        end else begin
            chk({pfx, ".rd_valid"}, {31'd0, v_o}, 32'd0);
            chk({pfx, ".rd_hold"}, d_o, m_last[n]);
        end
    endtask

    task automatic step();
        for (int n = 0; n < 2; n++) model_edge(n);
        @(posedge clk);
        #1;
        cyc++;
        for (int n = 0; n < 2; n++) check_out(n);
    endtask

    task automatic op(bit clr, bit we, logic [2:0] wa, logic [3:0] be,
                      logic [31:0] wd, bit re, logic [2:0] ra);
        t_clr_req = clr;
        t_wr_en   = we;
        t_wr_addr = wa;
        t_wr_be   = be;
        t_wr_data = wd;
        t_rd_en   = re;
        t_rd_addr = ra;
        step();
    endtask

    task automatic idle(int k);
        repeat (k) op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        t_clr_req = 1'b0; t_wr_en = 1'b0; t_rd_en = 1'b0;
        t_wr_addr = '0; t_rd_addr = '0; t_wr_be = '0; t_wr_data = '0;
        rst_n = 1'b0;
        #1;
        for (int n = 0; n < 2; n++) begin
            m_busy[n] = 1'b1;
            m_ptr[n]  = 0;
            e_err[n]  = 1'b0;
            m_last[n] = '0;
        end
        q_a.delete();
        q_b.delete();
        chk("A.rst_busy",  {31'd0, if_a.busy},     32'd1);
        chk("B.rst_busy",  {31'd0, if_b.busy},     32'd1);
        chk("A.rst_valid", {31'd0, if_a.rd_valid}, 32'd0);
        chk("B.rst_valid", {31'd0, if_b.rd_valid}, 32'd0);
        chk("A.rst_err",   {31'd0, if_a.err},      32'd0);
        chk("B.rst_err",   {31'd0, if_b.err},      32'd0);
        chk("A.rst_data",  if_a.rd_data,           32'd0);
        chk("B.rst_data",  if_b.rd_data,           32'd0);
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int n = 0; n < 2; n++)
            for (int a = 0; a < 8; a++) m_mem[n][a] = '0;
        rst_n = 1'b1;
        t_clr_req = 1'b0; t_wr_en = 1'b0; t_rd_en = 1'b0;
        t_wr_addr = '0; t_rd_addr = '0; t_wr_be = '0; t_wr_data = '0;
        #2;
        do_reset();

        // Write during the initial sweep is dropped with an err pulse.
        op(1'b0, 1'b1, 3'd2, 4'hF, 32'hDEADBEEF, 1'b0, 3'd0);
        idle(8);

        // Every address reads 0 after the sweep (B: 6,7 out of range).
        for (int a = 0; a < 8; a++) op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'(a));
        idle(3);

        // Byte lanes.
        op(1'b0, 1'b1, 3'd3, 4'hF, 32'hAABBCCDD, 1'b0, 3'd0);
        op(1'b0, 1'b1, 3'd3, 4'b0101, 32'h11223344, 1'b0, 3'd0);
        op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd3);
        op(1'b0, 1'b1, 3'd3, 4'h0, 32'hFFFFFFFF, 1'b0, 3'd0);
        op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd3);
        idle(3);

        // Same-address read during write, then the follow-up read.
        op(1'b0, 1'b1, 3'd5, 4'h1, 32'h0000005A, 1'b1, 3'd5);
        op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd5);
        idle(3);

        // Preload then back-to-back reads of every address.
        for (int a = 0; a < 8; a++)
            op(1'b0, 1'b1, 3'(a), 4'hF, 32'h01010101 * (a + 1) ^ 32'hC0DE0000, 1'b0, 3'd0);
        for (int a = 0; a < 8; a++) op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'(a));
        idle(3);

        // Clear accepted with a concurrent write; a read just before the
        // clear is still delivered; ops during the sweep are dropped.
        op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd4);
        op(1'b1, 1'b1, 3'd2, 4'hF, 32'h12345678, 1'b0, 3'd0);
        op(1'b0, 1'b1, 3'd2, 4'hF, 32'h87654321, 1'b0, 3'd0);
        op(1'b1, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd2);
        idle(8);
        op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd2);
        idle(2);

        // Range: write 7 / read 6, and both bad in one cycle.
        op(1'b0, 1'b1, 3'd7, 4'hF, 32'hBADBAD00, 1'b0, 3'd0);
        op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd6);
        op(1'b0, 1'b1, 3'd6, 4'hF, 32'h0BAD0BAD, 1'b1, 3'd7);
        op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd7);
        idle(3);

        // Reset in the middle of traffic, then sweep and read-back.
        op(1'b0, 1'b1, 3'd1, 4'hF, 32'hFEEDF00D, 1'b1, 3'd1);
        op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd1);
        do_reset();
        idle(4);
        do_reset();
        idle(9);
        for (int a = 0; a < 8; a++) op(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'(a));
        idle(3);

        // Random traffic.
        for (int k = 0; k < 400; k++)
            op($urandom_range(0, 24) == 0, 1'($urandom), 3'($urandom), 4'($urandom),
               $urandom, 1'($urandom), 3'($urandom));
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_sdp_clr.md
Name: ram_sdp_clr

Overview:
- Parametrised simple-dual-port synchronous RAM. Successor to the fixed 8x8 RAM.
- Adds configurable width and depth, byte-lane write enables, and selectable read latency.
- Adds read-during-write forwarding and a hardware clear sequencer that replaces a flop-based asynchronous memory reset.
- Used as a generic register-file / scratch buffer in the datapath.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- DEPTH, 8, number of words; 2..1024.
- ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- WR_FWD, 1, same-address read/write behaviour: 1 = read returns new data, 0 = read returns old data.

Ports:
- clk, input, 1, single clock; all logic is rising-edge.
- rst_n, input, 1, asynchronous active-low reset.
- clr_req, input, 1, single-cycle request to zero the whole memory.
- busy, output, 1, high while the clear sweep is running; ops are not accepted.
- wr_en, input, 1, write strobe.
- wr_addr, input, ADDR_W, write address.
- wr_be, input, DATA_W/8, byte-lane enables; bit i covers wr_data[8i+7:8i].
- wr_data, input, DATA_W, write data.
- rd_en, input, 1, read strobe.
- rd_addr, input, ADDR_W, read address.
- rd_data, output, DATA_W, read data.
- rd_valid, output, 1, one-cycle qualifier for rd_data.
- err, output, 1, one-cycle pulse when any requested op is dropped or out of range.

Behaviour:
- FSM states: CLEAR, IDLE. The sweep uses a pointer clr_ptr of width ADDR_W.
- Reset assertion (async):
  - state=CLEAR, clr_ptr=0, busy=1.
  - rd_data=0, rd_valid=0, err=0; internal read pipeline registers = 0.
  - Memory array is not reset asynchronously.
- CLEAR:
  - Each cycle writes mem[clr_ptr]=0, then clr_ptr++.
  - After writing DEPTH-1, goes to IDLE and busy drops on the next edge.
  - busy is high for exactly DEPTH cycles after rst_n deasserts. The first accepted op is on cycle DEPTH, counting the first post-reset edge as cycle 0.
- IDLE with clr_req=1: goes to CLEAR with clr_ptr=0; same sweep. clr_req during CLEAR is ignored; the sweep does not restart.
- Reset mid-sweep: sweep restarts from 0 after deassertion.
- Ops while busy, or in the same cycle clr_req is accepted:
  - wr_en/rd_en are ignored; no memory change; no rd_valid.
  - err pulses 1 cycle later.
- Write in IDLE: at the edge, for each i with wr_be[i]=1, mem[wr_addr] lane i <= wr_data lane i. Other lanes hold. wr_be=0 is a legal no-op; no err.
- Write with wr_addr >= DEPTH: dropped; err pulses.
- Read in IDLE:
  - RD_LAT=1: rd_data=mem[rd_addr] and rd_valid=1 at the next edge.
  - RD_LAT=2: one additional output register stage; rd_valid is aligned to it.
  - Back-to-back reads give one result per cycle.
  - rd_data holds its last value when rd_valid=0.
- Read with rd_addr >= DEPTH: rd_data=0 with rd_valid=1 at normal latency; err pulses.
- Same cycle, rd_addr==wr_addr, both legal:
  - WR_FWD=1: read returns the old word merged with the enabled new byte lanes.
  - WR_FWD=0: read returns the pre-write word.
- Reads already in the RD_LAT=2 pipeline when a clear starts still complete with their captured data.
- err timing: registered, high for one cycle per offending cycle. Wr and rd errors in the same cycle give a single pulse.

Test Plan:
- Reset/sweep: DEPTH=8. Pulse rst_n low mid-operation, release -> busy high 8 cycles then 0. Read of every address returns 0; rd_valid 1 cycle after each rd_en.
- Byte lanes: DATA_W=32. Write 0xAABBCCDD to addr 3 with be=4'hF, then 0x11223344 with be=4'b0101 -> read of addr 3 returns 0xAA22CC44.
- Forwarding: mem[5]=0x00. Same cycle wr addr5 data 0x5A be=1 and rd addr5 -> WR_FWD=1 gives 0x5A; WR_FWD=0 gives 0x00, and a next-cycle read gives 0x5A.
- Latency: RD_LAT=2, reads to addrs 0..7 on consecutive cycles after preload -> rd_valid starts 2 cycles after the first rd_en; 8 consecutive valid words in order.
- Clear vs ops: in IDLE, clr_req together with wr_en at addr 2 -> write dropped, err pulse, busy for DEPTH cycles. wr_en during busy -> err pulse; afterwards addr 2 reads 0.
- Range: DEPTH=6, ADDR_W=3. Write addr 7 -> err, no array change. Read addr 6 -> rd_data=0, rd_valid=1, err=1.
